// File: rtl/sprite_scan_pipe.sv
// Per-pixel sprite scanner: double-buffered sprite table, priority hit test,
// sprite-memory addressing and a 3-stage pipeline to the video mixer.
module sprite_scan_pipe #(
  parameter int N_SPRITES = 4,
  parameter int COORD_W   = 10,
  localparam int IDX_W    = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               frame_start,
  input  logic               active,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [5:0]         wr_sel,
  input  logic               wr_on,
  output logic [5:0]         spr_select,
  output logic [3:0]         spr_x,
  output logic [3:0]         spr_y,
  input  logic [1:0]         spr_data,
  output logic               pix_valid,
  output logic               pix_hit,
  output logic [1:0]         pix_color
);

  localparam logic [COORD_W:0] SPAN = (COORD_W+1)'(16);

  logic [COORD_W-1:0] sh_x   [N_SPRITES];
  logic [COORD_W-1:0] sh_y   [N_SPRITES];
  logic [5:0]         sh_sel [N_SPRITES];
  logic               sh_on  [N_SPRITES];
  logic [COORD_W-1:0] lv_x   [N_SPRITES];
  logic [COORD_W-1:0] lv_y   [N_SPRITES];
  logic [5:0]         lv_sel [N_SPRITES];
  logic               lv_on  [N_SPRITES];

  logic       any_p0;
  logic [5:0] sel_p0;
  logic [3:0] ox_p0;
  logic [3:0] oy_p0;
  logic       hit_p1, vld_p1;
  logic       hit_p2, vld_p2;

  // Unsigned difference one bit wider than the coordinate, so a borrow means
  // the pixel is left of / above the origin; no wrap-around across the edge.
  function automatic logic in_window(input logic [COORD_W-1:0] p,
                                     input logic [COORD_W-1:0] org);
    logic [COORD_W:0] d;
    d = {1'b0, p} - {1'b0, org};
    return (d < SPAN);
  endfunction

  // Shadow table takes writes any time; live table only changes on frame_start,
  // with a coincident write forwarded so it lands in the same commit.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        sh_x[i] <= '0; sh_y[i] <= '0; sh_sel[i] <= '0; sh_on[i] <= 1'b0;
        lv_x[i] <= '0; lv_y[i] <= '0; lv_sel[i] <= '0; lv_on[i] <= 1'b0;
      end
    end else begin
      if (wr_en) begin
        sh_x[wr_idx]   <= wr_x;
        sh_y[wr_idx]   <= wr_y;
        sh_sel[wr_idx] <= wr_sel;
        sh_on[wr_idx]  <= wr_on;
      end
      if (frame_start) begin
        for (int i = 0; i < N_SPRITES; i++) begin
          lv_x[i] <= sh_x[i]; lv_y[i] <= sh_y[i];
          lv_sel[i] <= sh_sel[i]; lv_on[i] <= sh_on[i];
        end
        if (wr_en) begin
          lv_x[wr_idx]   <= wr_x;
          lv_y[wr_idx]   <= wr_y;
          lv_sel[wr_idx] <= wr_sel;
          lv_on[wr_idx]  <= wr_on;
        end
      end
    end
  end

  // Stage 0: hit test; scanning from the bottom up leaves the lowest index.
  always_comb begin
    any_p0 = 1'b0;
    sel_p0 = '0;
    ox_p0  = '0;
    oy_p0  = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (lv_on[i] && in_window(hpos, lv_x[i]) && in_window(vpos, lv_y[i])) begin
        any_p0 = 1'b1;
        sel_p0 = lv_sel[i];
        ox_p0  = 4'(hpos - lv_x[i]);
        oy_p0  = 4'(vpos - lv_y[i]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_p1     <= 1'b0;
      hit_p1     <= 1'b0;
      spr_select <= '0;
      spr_x      <= '0;
      spr_y      <= '0;
      vld_p2     <= 1'b0;
      hit_p2     <= 1'b0;
      pix_valid  <= 1'b0;
      pix_hit    <= 1'b0;
      pix_color  <= '0;
    end else begin
      // Stage 1: memory address and hit flag
      vld_p1     <= active;
      hit_p1     <= active && any_p0;
      spr_select <= active ? sel_p0 : '0;
      spr_x      <= active ? ox_p0  : '0;
      spr_y      <= active ? oy_p0  : '0;
      // Stage 2: delay matching the memory's address register
      vld_p2     <= vld_p1;
      hit_p2     <= hit_p1;
      // Stage 3: transparency resolve; no fall-through to lower priorities
      pix_valid  <= vld_p2;
      pix_hit    <= hit_p2 && (spr_data != 2'b00);
      pix_color  <= hit_p2 ? spr_data : 2'b00;
    end
  end

endmodule

// File: tb/tb_sprite_scan_pipe.sv
// Directed bench for sprite_scan_pipe with a registered-address sprite memory model.
module tb_sprite_scan_pipe;

  logic       clock = 1'b0;
  logic       resetn;
  logic       frame_start;
  logic       active;
  logic [9:0] hpos, vpos;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [9:0] wr_x, wr_y;
  logic [5:0] wr_sel;
  logic       wr_on;
  logic [5:0] spr_select;
  logic [3:0] spr_x, spr_y;
  logic [1:0] spr_data;
  logic       pix_valid, pix_hit;
  logic [1:0] pix_color;

  int tests = 0;
  int fails = 0;

  sprite_scan_pipe #(.N_SPRITES(4), .COORD_W(10)) dut (
    .clock(clock), .resetn(resetn), .frame_start(frame_start), .active(active),
    .hpos(hpos), .vpos(vpos), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x),
    .wr_y(wr_y), .wr_sel(wr_sel), .wr_on(wr_on), .spr_select(spr_select),
    .spr_x(spr_x), .spr_y(spr_y), .spr_data(spr_data), .pix_valid(pix_valid),
    .pix_hit(pix_hit), .pix_color(pix_color)
  );

  always #5 clock = ~clock;

  // Sprite memory contents: pattern value for (sel, x, y)
  function automatic logic [1:0] mem(input int x, input int y, input int sel);
    return 2'((x + 2 * y + sel) % 4);
  endfunction

  logic [13:0] addr_q = '0;
  always @(posedge clock) addr_q <= {spr_select, spr_x, spr_y};
  assign spr_data = mem(int'(addr_q[7:4]), int'(addr_q[3:0]), int'(addr_q[13:8]));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    active = 1'b0;
    tick;
  endtask

  task automatic px(input int h, input int v);
    active = 1'b1;
    hpos = 10'(h);
    vpos = 10'(v);
    tick;
  endtask

  task automatic wr(input int idx, input int x, input int y, input int sel,
                    input int on, input int fs);
    active = 1'b0;
    wr_en = 1'b1;
    wr_idx = 2'(idx);
    wr_x = 10'(x);
    wr_y = 10'(y);
    wr_sel = 6'(sel);
    wr_on = 1'(on);
    frame_start = 1'(fs);
    tick;
    wr_en = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic commit;
    active = 1'b0;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      active = 1'($urandom); frame_start = 1'($urandom);
      hpos = 10'($urandom); vpos = 10'($urandom);
      wr_en = 1'($urandom); wr_idx = 2'($urandom); wr_x = 10'($urandom);
      wr_y = 10'($urandom); wr_sel = 6'($urandom); wr_on = 1'($urandom);
      tick;
    end
    tests++;
    if ({spr_select, spr_x, spr_y, pix_valid, pix_hit, pix_color} !== 18'd0) begin
      fails++;
      $display("FAIL reset_outputs: got sel=%0d x=%0d y=%0d v=%0d h=%0d c=%0d want all 0",
               spr_select, spr_x, spr_y, pix_valid, pix_hit, pix_color);
    end
    resetn = 1'b1; wr_en = 1'b0; frame_start = 1'b0;
    commit;
    px(0, 0);
    px(100, 50);
    px(1023, 1023);
    idle;
    idle;
    tests++;
    if (pix_hit !== 1'b0 || spr_select !== 6'd0) begin
      fails++;
      $display("FAIL reset_empty_table: got hit=%0d sel=%0d want 0 0", pix_hit, spr_select);
    end
  endtask

  task automatic test_single;
    logic       ev [22];
    logic       eh [22];
    logic [1:0] ec [22];
    int h, ox;
    logic act, hit;
    wr(0, 100, 50, 1, 1, 0);
    commit;
    for (int k = 0; k < 22; k++) begin
      h = 98 + k;
      act = (k < 20);
      hit = act && h >= 100 && h <= 115;
      ox = hit ? h - 100 : 0;
      if (act) px(h, 52);
      else idle;
      ev[k] = act;
      eh[k] = hit && (mem(ox, 2, 1) != 2'd0);
      ec[k] = hit ? mem(ox, 2, 1) : 2'd0;
      tests++;
      if (spr_x !== 4'(ox) || spr_y !== (hit ? 4'd2 : 4'd0) ||
          spr_select !== (hit ? 6'd1 : 6'd0)) begin
        fails++;
        $display("FAIL single_spr h=%0d: got sel=%0d x=%0d y=%0d want sel=%0d x=%0d y=%0d",
                 h, spr_select, spr_x, spr_y, hit ? 1 : 0, ox, hit ? 2 : 0);
      end
      if (k >= 2) begin
        tests++;
        if (pix_valid !== ev[k-2] || pix_hit !== eh[k-2] || pix_color !== ec[k-2]) begin
          fails++;
          $display("FAIL single_pix h=%0d: got v=%0d hit=%0d c=%0d want v=%0d hit=%0d c=%0d",
                   h - 2, pix_valid, pix_hit, pix_color, ev[k-2], eh[k-2], ec[k-2]);
        end
      end
    end
  endtask

  task automatic test_priority;
    wr(0, 100, 50, 0, 1, 0);
    wr(2, 108, 50, 1, 1, 0);
    commit;
    px(110, 55);
    tests++;
    if (spr_select !== 6'd0 || spr_x !== 4'd10 || spr_y !== 4'd5) begin
      fails++;
      $display("FAIL prio_spr: got sel=%0d x=%0d y=%0d want sel=0 x=10 y=5",
               spr_select, spr_x, spr_y);
    end
    px(120, 55);
    tests++;
    if (spr_select !== 6'd1 || spr_x !== 4'd12 || spr_y !== 4'd5) begin
      fails++;
      $display("FAIL prio_low_spr: got sel=%0d x=%0d y=%0d want sel=1 x=12 y=5",
               spr_select, spr_x, spr_y);
    end
    idle;
    tests++;
    if (pix_valid !== 1'b1 || pix_hit !== 1'b0 || pix_color !== 2'd0) begin
      fails++;
      $display("FAIL prio_transparent: got v=%0d hit=%0d c=%0d want v=1 hit=0 c=0",
               pix_valid, pix_hit, pix_color);
    end
    idle;
    tests++;
    if (pix_hit !== 1'b1 || pix_color !== 2'd3) begin
      fails++;
      $display("FAIL prio_low_pix: got hit=%0d c=%0d want hit=1 c=3", pix_hit, pix_color);
    end
  endtask

  task automatic test_commit;
    wr(0, 200, 50, 0, 1, 0);
    px(105, 52);
    tests++;
    if (spr_x !== 4'd5 || spr_y !== 4'd2) begin
      fails++;
      $display("FAIL commit_old_kept: got x=%0d y=%0d want x=5 y=2", spr_x, spr_y);
    end
    px(205, 52);
    tests++;
    if (spr_x !== 4'd0 || spr_y !== 4'd0) begin
      fails++;
      $display("FAIL commit_new_early: got x=%0d y=%0d want x=0 y=0", spr_x, spr_y);
    end
    commit;
    px(105, 52);
    tests++;
    if (spr_x !== 4'd0 || spr_y !== 4'd0) begin
      fails++;
      $display("FAIL commit_old_gone: got x=%0d y=%0d want x=0 y=0", spr_x, spr_y);
    end
    px(205, 52);
    tests++;
    if (spr_x !== 4'd5 || spr_y !== 4'd2) begin
      fails++;
      $display("FAIL commit_new_live: got x=%0d y=%0d want x=5 y=2", spr_x, spr_y);
    end
    wr(0, 300, 50, 3, 1, 1);
    px(305, 52);
    tests++;
    if (spr_select !== 6'd3 || spr_x !== 4'd5 || spr_y !== 4'd2) begin
      fails++;
      $display("FAIL commit_forward: got sel=%0d x=%0d y=%0d want sel=3 x=5 y=2",
               spr_select, spr_x, spr_y);
    end
  endtask

  task automatic test_clip;
    int vec [9][5] = '{
      '{1019, 1015, 0, 0, 0}, '{1020, 1015, 5, 0, 0}, '{1023, 1023, 5, 3, 8},
      '{1022, 1014, 0, 0, 0}, '{3, 1016, 0, 0, 0},    '{11, 1020, 0, 0, 0},
      '{0, 1015, 0, 0, 0},    '{1021, 2, 0, 0, 0},    '{1021, 1020, 5, 1, 5}};
    wr(0, 1020, 1015, 5, 1, 0);
    wr(2, 0, 0, 0, 0, 0);
    commit;
    for (int k = 0; k < 9; k++) begin
      px(vec[k][0], vec[k][1]);
      tests++;
      if (spr_select !== 6'(vec[k][2]) || spr_x !== 4'(vec[k][3]) ||
          spr_y !== 4'(vec[k][4])) begin
        fails++;
        $display("FAIL clip (%0d,%0d): got sel=%0d x=%0d y=%0d want sel=%0d x=%0d y=%0d",
                 vec[k][0], vec[k][1], spr_select, spr_x, spr_y,
                 vec[k][2], vec[k][3], vec[k][4]);
      end
    end
  endtask

  task automatic test_back_to_back;
    wr(1, 400, 400, 7, 1, 0);
    wr(1, 500, 400, 9, 1, 0);
    commit;
    px(505, 405);
    tests++;
    if (spr_select !== 6'd9 || spr_x !== 4'd5 || spr_y !== 4'd5) begin
      fails++;
      $display("FAIL b2b_last: got sel=%0d x=%0d y=%0d want sel=9 x=5 y=5",
               spr_select, spr_x, spr_y);
    end
    px(405, 405);
    tests++;
    if (spr_select !== 6'd0 || spr_x !== 4'd0 || spr_y !== 4'd0) begin
      fails++;
      $display("FAIL b2b_first_gone: got sel=%0d x=%0d y=%0d want 0 0 0",
               spr_select, spr_x, spr_y);
    end
  endtask

  task automatic test_midreset;
    px(1021, 1016);
    tests++;
    if (spr_select !== 6'd5) begin
      fails++;
      $display("FAIL midreset_pre: got sel=%0d want 5", spr_select);
    end
    px(1021, 1016);
    resetn = 1'b0;
    tick;
    tests++;
    if ({spr_select, spr_x, spr_y, pix_valid, pix_hit, pix_color} !== 18'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got sel=%0d x=%0d y=%0d v=%0d h=%0d c=%0d want all 0",
               spr_select, spr_x, spr_y, pix_valid, pix_hit, pix_color);
    end
    resetn = 1'b1;
    px(1021, 1016);
    tests++;
    if (spr_select !== 6'd0 || spr_x !== 4'd0 || spr_y !== 4'd0) begin
      fails++;
      $display("FAIL midreset_live_empty: got sel=%0d x=%0d y=%0d want 0 0 0",
               spr_select, spr_x, spr_y);
    end
    commit;
    px(1021, 1016);
    idle;
    idle;
    tests++;
    if (pix_valid !== 1'b1 || pix_hit !== 1'b0 || spr_select !== 6'd0) begin
      fails++;
      $display("FAIL midreset_shadow_empty: got v=%0d hit=%0d sel=%0d want v=1 hit=0 sel=0",
               pix_valid, pix_hit, spr_select);
    end
  endtask

  initial begin
    resetn = 1'b0; frame_start = 1'b0; active = 1'b0; hpos = '0; vpos = '0;
    wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_sel = '0; wr_on = 1'b0;
    test_reset;
    test_single;
    test_priority;
    test_commit;
    test_clip;
    test_back_to_back;
    test_midreset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
